// File: rtl/sysmon_pkg.sv
// -----------------------------------------------------------------------------
// sysmon_pkg
// Shared definitions for the system monitor poller: FSM state encoding, the
// data word written for a DRP read that never answered, and the DRP register
// addresses of the most commonly polled SYSMON/XADC status channels.
// -----------------------------------------------------------------------------
package sysmon_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      STAMP = 3'd4
   } state_t;

   // Written into a channel slot when drp_rdy never arrived.
   localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

   // Default SYSMON/XADC status register addresses.
   localparam logic [6:0] DRP_ADDR_TEMP   = 7'h00;
   localparam logic [6:0] DRP_ADDR_VCCINT = 7'h01;
   localparam logic [6:0] DRP_ADDR_VCCAUX = 7'h02;

endpackage

// File: rtl/sysmon_interval_timer.sv
// -----------------------------------------------------------------------------
// sysmon_interval_timer
// Free-running counter 0..INTERVAL_CYCLES-1 that raises tick once per period.
// tick is high whenever the counter sits at zero, i.e. in the cycle after each
// wrap and in the very first cycle after reset is released, so sweeps start
// immediately after reset and then exactly INTERVAL_CYCLES apart.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   tick  out  one-cycle sweep-start strobe
// -----------------------------------------------------------------------------
module sysmon_interval_timer #(
   parameter int INTERVAL_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      if (cnt_q == CW'(INTERVAL_CYCLES - 1)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/sysmon_poller.sv
// -----------------------------------------------------------------------------
// sysmon_poller
// Periodically reads CHANNEL_COUNT consecutive SYSMON DRP registers and writes
// each result into the monitor RAM at BASE_ADDR+index, followed by a 16-bit
// sweep counter at BASE_ADDR+CHANNEL_COUNT. A channel whose drp_rdy does not
// arrive within TIMEOUT_CYCLES gets 16'hFFFF and bumps timeout_count.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   drp_en/we/addr     DRP request side (we is tied low, reads only)
//   drp_do, drp_rdy    DRP response side
//   wen/waddr/wdata    RAM write port
//   busy               sweep in progress
//   timeout_count      saturating number of DRP timeouts since reset
//
// All outputs come straight from flops whose next value is decided from the
// current state, so they appear one cycle after the state that produces them.
// -----------------------------------------------------------------------------
module sysmon_poller
   import sysmon_pkg::*;
#(
   parameter int ADDR_WIDTH                          = 13,
   parameter int DATA_WIDTH                          = 16,
   parameter int DRP_ADDR_WIDTH                      = 7,
   parameter logic [DRP_ADDR_WIDTH-1:0] FIRST_DRP_ADDR = DRP_ADDR_TEMP,
   parameter int CHANNEL_COUNT                       = 8,
   parameter int BASE_ADDR                           = 0,
   parameter int INTERVAL_CYCLES                     = 100000,
   parameter int TIMEOUT_CYCLES                      = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      drp_en,
   output logic                      drp_we,
   output logic [DRP_ADDR_WIDTH-1:0] drp_addr,
   input  logic [15:0]               drp_do,
   input  logic                      drp_rdy,
   output logic                      wen,
   output logic [ADDR_WIDTH-1:0]     waddr,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic                      busy,
   output logic [15:0]               timeout_count
);

   localparam int IW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic tick;

   sysmon_interval_timer #(
      .INTERVAL_CYCLES(INTERVAL_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   state_t                    state_q,    state_d;
   logic [IW-1:0]             idx_q,      idx_d;
   logic [TW-1:0]             tmo_q,      tmo_d;
   logic [15:0]               data_q,     data_d;
   logic [15:0]               sweep_q,    sweep_d;
   logic [15:0]               tcount_q,   tcount_d;
   logic                      drp_en_q,   drp_en_d;
   logic [DRP_ADDR_WIDTH-1:0] drp_addr_q, drp_addr_d;
   logic                      wen_q,      wen_d;
   logic [ADDR_WIDTH-1:0]     waddr_q,    waddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q,    wdata_d;
   logic                      busy_q,     busy_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tmo_d      = tmo_q;
      data_d     = data_q;
      sweep_d    = sweep_q;
      tcount_d   = tcount_q;
      drp_en_d   = 1'b0;
      drp_addr_d = drp_addr_q;
      wen_d      = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      busy_d     = busy_q;

      case (state_q)
         IDLE: begin
            // Ticks arriving in any other state are simply not looked at.
            if (tick) begin
               state_d = REQ;
               busy_d  = 1'b1;
            end
         end
         REQ: begin
            drp_en_d   = 1'b1;
            drp_addr_d = DRP_ADDR_WIDTH'(int'(FIRST_DRP_ADDR) + int'(idx_q));
            tmo_d      = '0;
            state_d    = WAIT;
         end
         WAIT: begin
            // drp_rdy is checked first so a response in the timeout cycle wins.
            if (drp_rdy) begin
               data_d  = drp_do;
               state_d = WRITE;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
               data_d  = TIMEOUT_DATA;
               state_d = WRITE;
               if (tcount_q != 16'hFFFF) begin
                  tcount_d = tcount_q + 16'd1;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         WRITE: begin
            wen_d   = 1'b1;
            waddr_d = ADDR_WIDTH'(BASE_ADDR + int'(idx_q));
            wdata_d = DATA_WIDTH'(data_q);
            if (idx_q == IW'(CHANNEL_COUNT - 1)) begin
               state_d = STAMP;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = REQ;
            end
         end
         STAMP: begin
            wen_d   = 1'b1;
            waddr_d = ADDR_WIDTH'(BASE_ADDR + CHANNEL_COUNT);
            wdata_d = DATA_WIDTH'(sweep_q);
            sweep_d = sweep_q + 16'd1;
            idx_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         tmo_q      <= '0;
         data_q     <= '0;
         sweep_q    <= '0;
         tcount_q   <= '0;
         drp_en_q   <= 1'b0;
         drp_addr_q <= '0;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         data_q     <= data_d;
         sweep_q    <= sweep_d;
         tcount_q   <= tcount_d;
         drp_en_q   <= drp_en_d;
         drp_addr_q <= drp_addr_d;
         wen_q      <= wen_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign drp_en        = drp_en_q;
   assign drp_we        = 1'b0;
   assign drp_addr      = drp_addr_q;
   assign wen           = wen_q;
   assign waddr         = waddr_q;
   assign wdata         = wdata_q;
   assign busy          = busy_q;
   assign timeout_count = tcount_q;

endmodule

// File: tb/tb_sysmon_poller.sv
// -----------------------------------------------------------------------------
// tb_sysmon_poller
// Two poller instances: A (BASE_ADDR 0) exercises sweeps, timeouts and resets;
// B (BASE_ADDR 8188) checks RAM address wrap. Both use INTERVAL_CYCLES=200 and
// TIMEOUT_CYCLES=10. The DRP models answer drp_do=16'h1000+addr one cycle
// after drp_en; model A can be silenced on one address or overridden.
// -----------------------------------------------------------------------------
module tb_sysmon_poller;

   localparam int AW = 13;
   localparam int DW = 16;
   localparam int TO = 10;
   localparam int IV = 200;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a, rst_b;
   logic          drp_en_a, drp_we_a, drp_rdy_a, wen_a, busy_a;
   logic [6:0]    drp_addr_a;
   logic [15:0]   drp_do_a, tcnt_a;
   logic [AW-1:0] waddr_a;
   logic [DW-1:0] wdata_a;
   logic          drp_en_b, drp_we_b, drp_rdy_b, wen_b, busy_b;
   logic [6:0]    drp_addr_b;
   logic [15:0]   drp_do_b, tcnt_b;
   logic [AW-1:0] waddr_b;
   logic [DW-1:0] wdata_b;

   sysmon_poller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRP_ADDR_WIDTH(7), .FIRST_DRP_ADDR(7'h00),
      .CHANNEL_COUNT(8), .BASE_ADDR(0), .INTERVAL_CYCLES(IV), .TIMEOUT_CYCLES(TO)
   ) dut_a (
      .clk(clk), .rst(rst_a), .drp_en(drp_en_a), .drp_we(drp_we_a),
      .drp_addr(drp_addr_a), .drp_do(drp_do_a), .drp_rdy(drp_rdy_a),
      .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .busy(busy_a),
      .timeout_count(tcnt_a)
   );

   sysmon_poller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DRP_ADDR_WIDTH(7), .FIRST_DRP_ADDR(7'h00),
      .CHANNEL_COUNT(8), .BASE_ADDR(8188), .INTERVAL_CYCLES(IV), .TIMEOUT_CYCLES(TO)
   ) dut_b (
      .clk(clk), .rst(rst_b), .drp_en(drp_en_b), .drp_we(drp_we_b),
      .drp_addr(drp_addr_b), .drp_do(drp_do_b), .drp_rdy(drp_rdy_b),
      .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b),
      .timeout_count(tcnt_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int overlap = 0;
   int en_cyc [128];
   wr_t qa[$];
   wr_t qb[$];
   wr_t exp_q[$];

   // DRP model controls
   logic        model_on = 1'b1;
   logic        silent_on = 1'b0;
   logic [6:0]  silent_addr = 7'd0;
   logic        force_rdy = 1'b0;
   logic [15:0] force_do = 16'h0;
   logic        pend_a = 1'b0, nxt_a = 1'b0;
   logic [15:0] pend_do_a = 16'h0, nxt_do_a = 16'h0;
   logic        pend_b = 1'b0, nxt_b = 1'b0;
   logic [15:0] pend_do_b = 16'h0, nxt_do_b = 16'h0;

   assign drp_rdy_a = pend_a | force_rdy;
   assign drp_do_a  = force_rdy ? force_do : pend_do_a;
   assign drp_rdy_b = pend_b;
   assign drp_do_b  = pend_do_b;

   // Monitor + DRP response models, evaluated 1 time unit after each edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (drp_en_a) en_cyc[drp_addr_a] = cyc;
      if (wen_a) begin
         qa.push_back(wr_t'{waddr_a, wdata_a, cyc});
         $display("A write waddr=%0d wdata=%h cycle=%0d", waddr_a, wdata_a, cyc);
      end
      if (wen_a && drp_en_a) overlap++;
      if (wen_b && qb.size() < 9) begin
         qb.push_back(wr_t'{waddr_b, wdata_b, cyc});
         $display("B write waddr=%0d wdata=%h cycle=%0d", waddr_b, wdata_b, cyc);
      end
      pend_a    = nxt_a;
      pend_do_a = nxt_do_a;
      nxt_a     = model_on && drp_en_a && !(silent_on && drp_addr_a == silent_addr);
      nxt_do_a  = 16'h1000 + 16'(drp_addr_a);
      pend_b    = nxt_b;
      pend_do_b = nxt_do_b;
      nxt_b     = drp_en_b;
      nxt_do_b  = 16'h1000 + 16'(drp_addr_b);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_q(input string name, input int n, input int budget);
      int k = 0;
      while (qa.size() < n && k < budget) begin
         tick_n(1);
         k++;
      end
      checks++;
      if (qa.size() < n) begin
         errors++;
         $display("FAIL %s: got %0d writes expected %0d within %0d cycles", name, qa.size(), n, budget);
      end
   endtask

   task automatic wait_en_a(input string name, input logic [6:0] addr);
      int k = 0;
      while (!(drp_en_a && drp_addr_a == addr) && k < 300) begin
         tick_n(1);
         k++;
      end
      chk(name, {31'd0, drp_en_a}, 32'd1);
   endtask

   // Expected sweep: 8 channels from base, optional odd channel, then stamp.
   function automatic void build_exp(input int base, input int odd_ch,
                                     input logic [15:0] odd_data, input logic [15:0] stamp);
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(wr_t'{AW'(base + i), (i == odd_ch) ? odd_data : 16'h1000 + 16'(i), 0});
      end
      exp_q.push_back(wr_t'{AW'(base + 8), stamp, 0});
   endfunction

   task automatic cmp_q(input string name, input wr_t got[$], input int off);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (off + i < got.size()) begin
            chk($sformatf("%s[%0d].waddr", name, i), 32'(got[off + i].addr), 32'(exp_q[i].addr));
            chk($sformatf("%s[%0d].wdata", name, i), 32'(got[off + i].data), 32'(exp_q[i].data));
         end else begin
            checks++;
            errors++;
            $display("FAIL %s[%0d]: got no write expected waddr=%0d", name, i, exp_q[i].addr);
         end
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      tick_n(3);

      // Reset state
      chk("rst.drp_en",  {31'd0, drp_en_a}, 32'd0);
      chk("rst.drp_we",  {31'd0, drp_we_a}, 32'd0);
      chk("rst.drp_addr", 32'(drp_addr_a), 32'd0);
      chk("rst.wen",     {31'd0, wen_a},    32'd0);
      chk("rst.waddr",   32'(waddr_a),      32'd0);
      chk("rst.wdata",   32'(wdata_a),      32'd0);
      chk("rst.busy",    {31'd0, busy_a},   32'd0);
      chk("rst.tcount",  32'(tcnt_a),       32'd0);

      // Two normal sweeps
      qa.delete();
      rst_a = 1'b0;
      rst_b = 1'b0;
      wait_q("sweep0.ch7", 8, 100);
      chk("sweep0.busy_mid", {31'd0, busy_a}, 32'd1);
      wait_q("sweep0.stamp", 9, 20);
      tick_n(1);
      chk("sweep0.busy_after", {31'd0, busy_a}, 32'd0);
      build_exp(0, -1, 16'h0, 16'd0);
      cmp_q("sweep0", qa, 0);
      if (qa.size() > 0) chk("sweep0.latency", 32'(qa[0].cyc - en_cyc[0]), 32'd3);
      wait_q("sweep1", 18, 400);
      build_exp(0, -1, 16'h0, 16'd1);
      cmp_q("sweep1", qa, 9);
      if (qa.size() >= 18) chk("sweep1.period", 32'(qa[9].cyc - qa[0].cyc), 32'(IV));

      // Address wrap on instance B
      build_exp(8188, -1, 16'h0, 16'd0);
      cmp_q("wrap", qb, 0);

      // Silent channel 3 times out
      silent_on = 1'b1;
      silent_addr = 7'd3;
      rst_a = 1'b1;
      tick_n(2);
      qa.delete();
      rst_a = 1'b0;
      wait_q("tmo", 9, 200);
      build_exp(0, 3, 16'hFFFF, 16'd0);
      cmp_q("tmo", qa, 0);
      if (qa.size() > 3) chk("tmo.latency", 32'(qa[3].cyc - en_cyc[3]), 32'(TO + 2));
      chk("tmo.tcount", 32'(tcnt_a), 32'd1);

      // Reset while waiting on channel 5, late drp_rdy afterwards
      silent_addr = 7'd5;
      rst_a = 1'b1;
      tick_n(2);
      rst_a = 1'b0;
      wait_en_a("abort.reach_ch5", 7'd5);
      tick_n(3);
      qa.delete();
      rst_a = 1'b1;
      tick_n(1);
      chk("abort.wen",    {31'd0, wen_a},    32'd0);
      chk("abort.busy",   {31'd0, busy_a},   32'd0);
      chk("abort.drp_en", {31'd0, drp_en_a}, 32'd0);
      silent_on = 1'b0;
      force_do  = 16'h5555;
      force_rdy = 1'b1;
      tick_n(1);
      rst_a = 1'b0;
      tick_n(1);
      force_rdy = 1'b0;
      wait_q("abort.restart", 9, 200);
      build_exp(0, -1, 16'h0, 16'd0);
      cmp_q("abort", qa, 0);
      chk("abort.tcount", 32'(tcnt_a), 32'd0);

      // drp_rdy in the exact timeout cycle of channel 0
      model_on = 1'b0;
      rst_a = 1'b1;
      tick_n(2);
      qa.delete();
      rst_a = 1'b0;
      wait_en_a("race.reach_ch0", 7'd0);
      tick_n(TO);
      force_do  = 16'h0ABC;
      force_rdy = 1'b1;
      model_on  = 1'b1;
      tick_n(1);
      force_rdy = 1'b0;
      wait_q("race", 9, 200);
      build_exp(0, 0, 16'h0ABC, 16'd0);
      cmp_q("race", qa, 0);
      if (qa.size() > 0) chk("race.latency", 32'(qa[0].cyc - en_cyc[0]), 32'(TO + 2));
      chk("race.tcount", 32'(tcnt_a), 32'd0);

      chk("wen_drp_en_overlap", 32'(overlap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysmon_poller.md
Name: sysmon_poller

Overview:
- Write-side producer for the acquisition-node system monitor storage.
- Periodically sweeps a contiguous range of SYSMON/XADC DRP status registers using DRP read handshakes.
- Writes each result, then a sweep counter, into the system monitor dual-port RAM write port (wen/waddr/wdata) for host readout.
- Single clock domain. It sits between the SYSMON primitive DRP and the storage RAM.

Parameters:
- ADDR_WIDTH, 13, width of the RAM write address.
- DATA_WIDTH, 16, width of the RAM write data; must be ≥16.
- DRP_ADDR_WIDTH, 7, SYSMON DRP address width.
- FIRST_DRP_ADDR, 7'h00, first DRP register polled.
- CHANNEL_COUNT, 8, number of consecutive DRP registers polled per sweep (1..64).
- BASE_ADDR, 0, RAM address of the first channel slot.
- INTERVAL_CYCLES, 100000, clocks between sweep starts (≥ CHANNEL_COUNT*(TIMEOUT_CYCLES+4)+4).
- TIMEOUT_CYCLES, 255, maximum clocks waiting for drp_rdy.

Ports:
- clk  in  1  system clock; also drives the DRP and the RAM write clock.
- rst  in  1  synchronous, active-high reset.
- drp_en  out  1  DRP enable, one-cycle pulse per read.
- drp_we  out  1  DRP write enable, constant 0.
- drp_addr  out  DRP_ADDR_WIDTH  DRP register address.
- drp_do  in  16  DRP read data.
- drp_rdy  in  1  DRP data-valid strobe.
- wen  out  1  RAM write enable.
- waddr  out  ADDR_WIDTH  RAM write address.
- wdata  out  DATA_WIDTH  RAM write data.
- busy  out  1  high while a sweep is in progress.
- timeout_count  out  16  saturating count of DRP timeouts since reset.

Behaviour:
- Reset values: all outputs 0. State IDLE, channel index 0, sweep counter 0, interval counter 0.
  - Reset mid-sweep aborts immediately with no further wen.
  - A late drp_rdy after reset is ignored.
- Interval counter:
  - Counts clk cycles 0..INTERVAL_CYCLES-1 and wraps.
  - Asserts tick on wrap, and on the first cycle after reset deassert, so the first sweep starts at once.
  - Runs free, independent of FSM state.
- FSM states:
  - IDLE: on tick go to REQ; busy=1 from that cycle onward. A tick seen outside IDLE is dropped.
  - REQ: drp_en=1 for exactly one cycle, drp_addr=FIRST_DRP_ADDR+index. Go to WAIT and clear the timeout counter.
  - WAIT: hold drp_addr.
    - On drp_rdy: latch drp_do, go to WRITE.
    - Else if the timeout counter reaches TIMEOUT_CYCLES: latch 16'hFFFF, increment timeout_count (saturates at 16'hFFFF), go to WRITE.
    - drp_rdy arriving in the same cycle as the timeout wins; no increment.
  - WRITE: wen=1 for one cycle, waddr=BASE_ADDR+index, wdata=latched value zero-extended to DATA_WIDTH.
    - If index==CHANNEL_COUNT-1, go to STAMP.
    - Else increment index and go to REQ.
  - STAMP: wen=1, waddr=BASE_ADDR+CHANNEL_COUNT, wdata=sweep counter (16-bit, wraps 16'hFFFF→0), zero-extended. Then increment the sweep counter, index=0, busy=0, go to IDLE.
- Latency:
  - Per channel: REQ (1) + WAIT (drp_rdy latency, ≥1) + WRITE (1).
  - With drp_rdy 1 cycle after drp_en, wen occurs 3 cycles after drp_en.
- Outputs are registered. wen is never asserted in the same cycle as drp_en.
- drp_rdy received outside WAIT is ignored.
- The first sweep after reset writes stamp value 0.
- The address sum is truncated to ADDR_WIDTH and wraps silently.

Decomposition:
- Shared package `sysmon_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, WRITE, STAMP);
  - the timeout data constant 16'hFFFF;
  - default DRP register addresses for temperature/VCCINT/VCCAUX.
- One natural sub-module: `sysmon_interval_timer`, the free-running interval counter producing tick. FSM and datapath stay in the top module.

Test Plan:
- Reset, then DRP model answering with drp_do=16'h1000+addr, drp_rdy 1 cycle after drp_en -> 8 writes: waddr 0..7 carrying 16'h1000..16'h1007, then waddr 8 carrying 0. busy falls after the stamp write; no wen until the next tick.
- Two sweeps with INTERVAL_CYCLES=200 -> second stamp write carries 1; channel data is rewritten at the same addresses; sweeps start 200 cycles apart.
- DRP model silent on address 3, TIMEOUT_CYCLES=10 -> waddr 3 gets 16'hFFFF 11–12 cycles after drp_en; timeout_count=1; remaining channels still written.
- Assert rst while in WAIT on channel 5, then deliver drp_rdy -> no wen during or after reset until the restarted sweep; that sweep starts at channel 0 with stamp 0.
- drp_rdy asserted in the exact timeout cycle with drp_do=16'h0ABC -> 16'h0ABC written; timeout_count unchanged.
- BASE_ADDR=8188, ADDR_WIDTH=13, CHANNEL_COUNT=8 -> waddr sequence 8188..8191, 0..3, stamp at 4.
